// File: rtl/hilo_div_if.sv
// Issue/result handshake between the execute-stage stall logic and the HI/LO divider.
// master = pipeline side, slave = divider side.
interface hilo_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             div_by_zero;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  busy, done, lo, hi, div_by_zero
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output busy, done, lo, hi, div_by_zero
  );
endinterface

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Returns quotient on lo and remainder on hi, with a one-cycle done pulse.
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      rst,
  hilo_div_if.slave dif
);

  typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt_p1;
  logic [2*WIDTH:0]       rem_p1;
  logic [WIDTH-1:0]       div_p1;
  logic                   q_neg_p1;
  logic                   r_neg_p1;
  logic                   busy_q;
  logic                   done_q;
  logic                   dbz_q;
  logic [WIDTH-1:0]       lo_q;
  logic [WIDTH-1:0]       hi_q;

  logic [WIDTH+1:0]       diff;
  logic [2*WIDTH:0]       rem_nxt;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic en);
    // The most negative value maps onto itself and is read as unsigned.
    return (en && v < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Restoring step: trial-subtract the divisor from the shifted upper half.
  always_comb begin
    diff    = rem_p1[2*WIDTH:WIDTH-1] - {2'b00, div_p1};
    rem_nxt = {rem_p1[2*WIDTH-1:0], 1'b0};
    if (!diff[WIDTH+1])
      rem_nxt = {diff[WIDTH:0], rem_p1[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      cnt_p1 <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dif.start && !dif.cancel) begin
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
            cnt_p1   <= '0;
            div_p1   <= abs_val(dif.divisor, dif.signed_div);
            rem_p1   <= {{(WIDTH+1){1'b0}}, abs_val(dif.dividend, dif.signed_div)};
            q_neg_p1 <= dif.signed_div & (dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1]);
            r_neg_p1 <= dif.signed_div & dif.dividend[WIDTH-1];
            state    <= (dif.divisor == '0) ? DIV_ZERO : DIV_ON;
          end
        end
        DIV_ZERO: begin
          if (dif.cancel) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state  <= DIV_END;
            lo_q   <= '0;
            hi_q   <= '0;
            dbz_q  <= 1'b1;
            done_q <= 1'b1;
          end
        end
        DIV_ON: begin
          if (dif.cancel) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            rem_p1 <= rem_nxt;
            cnt_p1 <= cnt_p1 + CNT_W'(1);
            // Results are registered on the way into DIV_END so they are valid with done.
            if (cnt_p1 == CNT_W'(WIDTH-1)) begin
              state  <= DIV_END;
              done_q <= 1'b1;
              lo_q   <= apply_sign(rem_nxt[WIDTH-1:0], q_neg_p1);
              hi_q   <= apply_sign(rem_nxt[2*WIDTH-1:WIDTH], r_neg_p1);
            end
          end
        end
        DIV_END: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.lo          = lo_q;
  assign dif.hi          = hi_q;
  assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: expected results are queued at issue and
// compared when done pulses.
module tb_hilo_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  hilo_div_if #(.WIDTH(W)) dif();

  hilo_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sd_b, q, r;
    logic [63:0] qv, rv;
    if (b == '0) begin
      e.lo = '0; e.hi = '0; e.dbz = 1'b1;
    end else if (sd) begin
      sa   = longint'($signed(a));
      sd_b = longint'($signed(b));
      q    = sa / sd_b;
      r    = sa % sd_b;
      qv   = q;
      rv   = r;
      e.lo = qv[W-1:0]; e.hi = rv[W-1:0]; e.dbz = 1'b0;
    end else begin
      e.lo = a / b; e.hi = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start, then scrambles operands to show they are not re-sampled.
  task automatic issue(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    dif.signed_div = sd;
    dif.dividend   = a;
    dif.divisor    = b;
    dif.start      = 1'b1;
    if (push) exp_q.push_back(model(sd, a, b));
    step();
    dif.start      = 1'b0;
    dif.dividend   = $urandom;
    dif.divisor    = $urandom;
    dif.signed_div = ~sd;
  endtask

  task automatic wait_done(input int exp_k, input string tag, input bit cancel_at_end);
    int   k = 0;
    bit   all_busy = 1'b1;
    exp_t e;
    while (dif.done !== 1'b1 && k < 100) begin
      if (dif.busy !== 1'b1) all_busy = 1'b0;
      step();
      k++;
    end
    chk({tag, "_done_seen"}, dif.done, 1);
    chk({tag, "_latency"}, k, exp_k);
    chk({tag, "_busy_during"}, all_busy, 1);
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_lo"}, dif.lo, e.lo);
      chk({tag, "_hi"}, dif.hi, e.hi);
      chk({tag, "_dbz"}, dif.div_by_zero, e.dbz);
    end
    if (cancel_at_end) dif.cancel = 1'b1;
    step();
    dif.cancel = 1'b0;
    chk({tag, "_done_pulse"}, dif.done, 0);
    chk({tag, "_busy_after"}, dif.busy, 0);
  endtask

  task automatic count_done(input int n, input string tag);
    int nd = 0;
    for (int i = 0; i < n; i++) begin
      if (dif.done === 1'b1) nd++;
      step();
    end
    chk({tag, "_no_done"}, nd, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit           sd;
    logic [W-1:0] lo_prev, hi_prev;

    rst = 1'b1;
    dif.start = 1'b0; dif.signed_div = 1'b0; dif.cancel = 1'b0;
    dif.dividend = '0; dif.divisor = '0;
    step(); step();
    chk("rst_busy", dif.busy, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_dbz", dif.div_by_zero, 0);
    chk("rst_lo", dif.lo, 0);
    chk("rst_hi", dif.hi, 0);
    rst = 1'b0;
    step();

    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done(W, "divu_100_7", 1'b0);

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(W, "div_m7_2", 1'b0);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(W, "div_7_m2", 1'b0);

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(W, "div_ovf", 1'b0);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(W, "divu_edge", 1'b0);

    issue(1'b0, 32'd5, 32'd0, 1'b1);
    wait_done(1, "div_zero", 1'b0);
    issue(1'b0, 32'd10, 32'd3, 1'b1);
    chk("dbz_cleared", dif.div_by_zero, 0);
    wait_done(W, "divu_10_3", 1'b0);

    // Start with cancel asserted must not be accepted.
    dif.start = 1'b1; dif.cancel = 1'b1; dif.divisor = 32'd3; dif.dividend = 32'd9;
    step();
    dif.start = 1'b0; dif.cancel = 1'b0;
    chk("start_cancel_ignored", dif.busy, 0);

    // Cancel mid-operation at T+10.
    lo_prev = dif.lo; hi_prev = dif.hi;
    issue(1'b0, 32'd1000, 32'd10, 1'b0);
    for (int i = 0; i < 9; i++) step();
    dif.cancel = 1'b1;
    step();
    dif.cancel = 1'b0;
    chk("cancel_busy", dif.busy, 0);
    chk("cancel_done", dif.done, 0);
    chk("cancel_lo_held", dif.lo, lo_prev);
    chk("cancel_hi_held", dif.hi, hi_prev);
    count_done(40, "cancel");

    // Reset at T+20 of a fresh operation.
    issue(1'b1, 32'hFFFF_FF00, 32'd5, 1'b0);
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", dif.busy, 0);
    chk("midrst_done", dif.done, 0);
    chk("midrst_lo", dif.lo, 0);
    chk("midrst_hi", dif.hi, 0);
    chk("midrst_dbz", dif.div_by_zero, 0);
    count_done(40, "midrst");

    // Second start while busy is dropped; one done with the first op's result.
    issue(1'b0, 32'd81, 32'd9, 1'b1);
    for (int i = 0; i < 4; i++) step();
    dif.start = 1'b1; dif.dividend = 32'd1; dif.divisor = 32'd1;
    step();
    dif.start = 1'b0;
    wait_done(W - 5, "busy_start", 1'b0);
    count_done(40, "busy_start_single");

    // Cancel during the done cycle does not suppress the result.
    issue(1'b0, 32'd9, 32'd2, 1'b1);
    wait_done(W, "cancel_at_end", 1'b1);

    for (int n = 0; n < 6; n++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      issue(sd, a, b, 1'b1);
      wait_done(W, $sformatf("rand%0d", n), 1'b0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
